// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cpu_mem_arbiter
// Purpose  : Merges the core's fetch and data ports onto one variable-latency
//            memory port. It has fixed data priority, a bus timeout and a
//            sticky error flag. Defining CPU_MEM_ARB_FETCH_BUF_EN adds a
//            one-entry fetch buffer.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    localparam int                CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  c_TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE    = CNT_W'(1);
    localparam logic [DATA_W-1:0] c_ABORT_DATA = DATA_W'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_owner_d;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_if_ready;
    logic                r_d_ready;
    logic                r_mem_re;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_bus_err;
    logic                w_fetch_hit;
    logic [DATA_W-1:0]   w_buf_data;

    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign if_ready  = r_if_ready;
    assign d_ready   = r_d_ready;
    assign mem_re    = r_mem_re;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign bus_err   = r_bus_err;

`ifdef CPU_MEM_ARB_FETCH_BUF_EN
    logic                r_buf_valid;
    logic [ADDR_W-1:0]   r_buf_tag;
    logic [DATA_W-1:0]   r_buf_data;

    assign w_fetch_hit = r_buf_valid && (if_addr == r_buf_tag);
    assign w_buf_data  = r_buf_data;

    // Invalidate on a store to the tag at issue time, so a later fetch re-reads memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_buf_data  <= '0;
        end else if (r_state == S_IDLE && d_req && d_we && d_addr == r_buf_tag) begin
            r_buf_valid <= 1'b0;
        end else if (r_state == S_BUSY && !r_owner_d) begin
            if (mem_ack) begin
                r_buf_valid <= 1'b1;
                r_buf_tag   <= r_mem_addr;
                r_buf_data  <= mem_rdata;
            end else if (r_cnt == c_TMO_LAST) begin
                r_buf_valid <= 1'b0;
            end
        end
    end
`else
    assign w_fetch_hit = 1'b0;
    assign w_buf_data  = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_owner_d   <= 1'b0;
            r_cnt       <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (d_req) begin
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_mem_re    <= ~d_we;
                        r_mem_we    <= d_we;
                        r_owner_d   <= 1'b1;
                        r_state     <= S_BUSY;
                    end else if (if_req) begin
                        r_owner_d <= 1'b0;
                        if (w_fetch_hit) begin
                            r_if_rdata <= w_buf_data;
                            r_if_ready <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_mem_addr <= if_addr;
                            r_mem_re   <= 1'b1;
                            r_state    <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        r_mem_re <= 1'b0;
                        r_mem_we <= 1'b0;
                        if (r_owner_d) begin
                            if (r_mem_re) begin
                                r_d_rdata <= mem_rdata;
                            end
                            r_d_ready <= 1'b1;
                        end else begin
                            r_if_rdata <= mem_rdata;
                            r_if_ready <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else if (r_cnt == c_TMO_LAST) begin
                        r_mem_re  <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_bus_err <= 1'b1;
                        if (r_owner_d) begin
                            r_d_rdata <= c_ABORT_DATA;
                            r_d_ready <= 1'b1;
                        end else begin
                            r_if_rdata <= c_ABORT_DATA;
                            r_if_ready <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_DONE: begin
                    r_if_ready <= 1'b0;
                    r_d_ready  <= 1'b0;
                    r_cnt      <= '0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cpu_mem_arbiter
// Purpose  : Self-checking bench for cpu_mem_arbiter. It has a behavioural
//            memory responder and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_arbiter;

    localparam int TMO = 8;
`ifdef CPU_MEM_ARB_FETCH_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, mem_re, mem_we, bus_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int mem_wait     = 0;

    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] exp_if_rdata, exp_d_rdata;
    bit          exp_bus_err;
    bit          bv;
    logic [31:0] btag, bdata;

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1357;
    endfunction

    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // Memory: acks in the (mem_wait+1)-th strobe cycle, garbage data otherwise.
    initial begin
        int scnt;
        scnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_re || mem_we) begin
                if (scnt == mem_wait) begin
                    mem_ack = 1'b1;
                    if (mem_we) mem_arr[mem_addr] = mem_wdata;
                    mem_rdata = mem_re ? env_rd(mem_addr) : $urandom;
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = $urandom;
                end
                scnt++;
            end else begin
                mem_ack = 1'b0;
                mem_rdata = $urandom;
                scnt = 0;
            end
        end
    end

    // One access from request to ready plus one trailing cycle.
    task automatic drive_txn(input bit is_d, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int w,
                             output int lat, output int n_re, output int n_we,
                             output logic [31:0] saddr, output logic [31:0] swdata,
                             output logic [31:0] rdata, output bit other,
                             output bit after, output bit berr);
        bit own, oth;
        mem_wait = w;
        @(negedge clk);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; if_req = 1'b0;
        end else begin
            if_req = 1'b1; if_addr = addr; d_req = 1'b0;
        end
        lat = -1; n_re = 0; n_we = 0; other = 1'b0; saddr = 'x; swdata = 'x;
        rdata = 'x; berr = 1'b0;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clk);
            if (mem_re || mem_we) begin
                if (n_re + n_we == 0) begin
                    saddr = mem_addr;
                    swdata = mem_wdata;
                end
                n_re += int'(mem_re);
                n_we += int'(mem_we);
            end
            own = is_d ? d_ready : if_ready;
            oth = is_d ? if_ready : d_ready;
            if (oth) other = 1'b1;
            if (own) begin
                lat = n;
                rdata = is_d ? d_rdata : if_rdata;
                berr = bus_err;
                d_req = 1'b0;
                if_req = 1'b0;
            end
        end
        d_req = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        after = if_ready || d_ready;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({if_ready, d_ready, mem_re, mem_we, bus_err} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 00000", {if_ready, d_ready, mem_re, mem_we, bus_err});
        end
        tests_run++;
        if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 128'b0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h %h %h %h expected all zero", if_rdata, d_rdata, mem_addr, mem_wdata);
        end
        rst = 1'b1;
        exp_if_rdata = '0; exp_d_rdata = '0; exp_bus_err = 1'b0; bv = 1'b0;
    endtask

    task automatic test_zero_wait_fetch();
        int lat, nre, nwe; logic [31:0] sa, sw, rd; bit oth, aft, be;
        drive_txn(1'b0, 1'b0, 32'h0, 32'h0, 0, lat, nre, nwe, sa, sw, rd, oth, aft, be);
        tests_run++;
        if (lat !== 2) begin tests_failed++; $display("FAIL zw_fetch_latency: got %0d expected 2", lat); end
        tests_run++;
        if (nre !== 1 || nwe !== 0) begin tests_failed++; $display("FAIL zw_fetch_strobe: got re=%0d we=%0d expected re=1 we=0", nre, nwe); end
        tests_run++;
        if (sa !== 32'h0) begin tests_failed++; $display("FAIL zw_fetch_addr: got %h expected 00000000", sa); end
        tests_run++;
        if (rd !== 32'h2402_0005) begin tests_failed++; $display("FAIL zw_fetch_data: got %h expected 24020005", rd); end
        tests_run++;
        if (oth !== 1'b0 || aft !== 1'b0) begin tests_failed++; $display("FAIL zw_fetch_pulse: other=%0d after=%0d expected 0 0", oth, aft); end
        exp_if_rdata = 32'h2402_0005;
        bv = 1'b1; btag = 32'h0; bdata = 32'h2402_0005;
    endtask

    task automatic test_wait_load();
        int lat, nre, nwe; logic [31:0] sa, sw, rd; bit oth, aft, be;
        drive_txn(1'b1, 1'b0, 32'h100, 32'h0, 3, lat, nre, nwe, sa, sw, rd, oth, aft, be);
        tests_run++;
        if (nre !== 4 || nwe !== 0) begin tests_failed++; $display("FAIL load_strobe: got re=%0d we=%0d expected re=4 we=0", nre, nwe); end
        tests_run++;
        if (lat !== 5) begin tests_failed++; $display("FAIL load_latency: got %0d expected 5", lat); end
        tests_run++;
        if (rd !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL load_data: got %h expected cafef00d", rd); end
        tests_run++;
        if (oth !== 1'b0 || be !== 1'b0) begin tests_failed++; $display("FAIL load_side: if_ready_seen=%0d bus_err=%0d expected 0 0", oth, be); end
        exp_d_rdata = 32'hCAFE_F00D;
    endtask

    task automatic test_simultaneous();
        int d_lat, i_lat, f_first; bit first_seen, both, first_we;
        logic [31:0] first_addr, first_wdata, i_data, d_data;
        mem_wait = 0;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678;
        if_req = 1'b1; if_addr = 32'h44;
        d_lat = -1; i_lat = -1; f_first = -1; first_seen = 1'b0; both = 1'b0;
        first_we = 1'b0; first_addr = 'x; first_wdata = 'x; i_data = 'x; d_data = 'x;
        for (int n = 1; n <= 20 && i_lat < 0; n++) begin
            @(negedge clk);
            if ((mem_re || mem_we) && !first_seen) begin
                first_seen = 1'b1; first_we = mem_we; first_addr = mem_addr; first_wdata = mem_wdata;
            end
            if (mem_re && mem_addr == 32'h44 && f_first < 0) f_first = n;
            if (if_ready && d_ready) both = 1'b1;
            if (d_ready) begin d_lat = n; d_data = d_rdata; d_req = 1'b0; end
            if (if_ready) begin i_lat = n; i_data = if_rdata; if_req = 1'b0; end
        end
        d_req = 1'b0; if_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (first_we !== 1'b1 || first_addr !== 32'h40 || first_wdata !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL prio_first_access: got we=%0d addr=%h wdata=%h expected we=1 addr=00000040 wdata=12345678", first_we, first_addr, first_wdata);
        end
        tests_run++;
        if (d_lat !== 2 || i_lat !== 5 || f_first !== 4) begin
            tests_failed++;
            $display("FAIL prio_timing: got d_lat=%0d i_lat=%0d fetch_strobe=%0d expected 2 5 4", d_lat, i_lat, f_first);
        end
        ref_mem[32'h40] = 32'h1234_5678;
        tests_run++;
        if (i_data !== ref_rd(32'h44) || d_data !== exp_d_rdata || both !== 1'b0) begin
            tests_failed++;
            $display("FAIL prio_data: got if=%h d=%h both=%0d expected if=%h d=%h both=0", i_data, d_data, both, ref_rd(32'h44), exp_d_rdata);
        end
        exp_if_rdata = ref_rd(32'h44);
        bv = 1'b1; btag = 32'h44; bdata = ref_rd(32'h44);
    endtask

    task automatic test_timeout();
        int lat, nre, nwe; logic [31:0] sa, sw, rd; bit oth, aft, be;
        tests_run++;
        if (bus_err !== 1'b0) begin tests_failed++; $display("FAIL tmo_pre_err: got %0d expected 0", bus_err); end
        drive_txn(1'b1, 1'b0, 32'h200, 32'h0, 100, lat, nre, nwe, sa, sw, rd, oth, aft, be);
        tests_run++;
        if (nre !== TMO || lat !== TMO + 1) begin tests_failed++; $display("FAIL tmo_timing: got strobe=%0d lat=%0d expected %0d %0d", nre, lat, TMO, TMO + 1); end
        tests_run++;
        if (rd !== 32'hDEAD_BEEF || be !== 1'b1) begin tests_failed++; $display("FAIL tmo_result: got data=%h err=%0d expected deadbeef 1", rd, be); end
        repeat (20) @(negedge clk);
        tests_run++;
        if (bus_err !== 1'b1) begin tests_failed++; $display("FAIL tmo_sticky: got %0d expected 1", bus_err); end
        exp_d_rdata = 32'hDEAD_BEEF;
        exp_bus_err = 1'b1;
    endtask

    task automatic test_reset_mid_access();
        bit saw_rdy;
        mem_wait = 100;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        @(posedge clk);
        @(posedge clk);
        #1;
        tests_run++;
        if (mem_re !== 1'b1) begin tests_failed++; $display("FAIL rstmid_busy: mem_re got %0d expected 1", mem_re); end
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({mem_re, mem_we, if_ready, d_ready, bus_err} !== 5'b0) begin
            tests_failed++;
            $display("FAIL rstmid_async: got %b expected 00000", {mem_re, mem_we, if_ready, d_ready, bus_err});
        end
        tests_run++;
        if (d_rdata !== 32'h0 || mem_addr !== 32'h0) begin tests_failed++; $display("FAIL rstmid_regs: got d_rdata=%h mem_addr=%h expected 0 0", d_rdata, mem_addr); end
        d_req = 1'b0;
        saw_rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (d_ready || if_ready) saw_rdy = 1'b1;
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (d_ready || if_ready) saw_rdy = 1'b1;
        end
        tests_run++;
        if (saw_rdy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_no_ready: got ready_seen=%0d expected 0", saw_rdy); end
        exp_if_rdata = '0; exp_d_rdata = '0; exp_bus_err = 1'b0; bv = 1'b0;
    endtask

`ifdef CPU_MEM_ARB_FETCH_BUF_EN
    task automatic test_fetch_buffer();
        int lat, nre, nwe; logic [31:0] sa, sw, rd; bit oth, aft, be;
        drive_txn(1'b0, 1'b0, 32'h8, 32'h0, 0, lat, nre, nwe, sa, sw, rd, oth, aft, be);
        tests_run++;
        if (lat !== 2 || nre !== 1 || rd !== ref_rd(32'h8)) begin tests_failed++; $display("FAIL buf_miss: got lat=%0d re=%0d data=%h expected 2 1 %h", lat, nre, rd, ref_rd(32'h8)); end
        drive_txn(1'b0, 1'b0, 32'h8, 32'h0, 0, lat, nre, nwe, sa, sw, rd, oth, aft, be);
        tests_run++;
        if (lat !== 1 || nre !== 0 || rd !== ref_rd(32'h8)) begin tests_failed++; $display("FAIL buf_hit: got lat=%0d re=%0d data=%h expected 1 0 %h", lat, nre, rd, ref_rd(32'h8)); end
        drive_txn(1'b1, 1'b1, 32'h8, 32'hA5A5_1234, 0, lat, nre, nwe, sa, sw, rd, oth, aft, be);
        ref_mem[32'h8] = 32'hA5A5_1234;
        drive_txn(1'b0, 1'b0, 32'h8, 32'h0, 0, lat, nre, nwe, sa, sw, rd, oth, aft, be);
        tests_run++;
        if (lat !== 2 || nre !== 1 || rd !== 32'hA5A5_1234) begin tests_failed++; $display("FAIL buf_invalidate: got lat=%0d re=%0d data=%h expected 2 1 a5a51234", lat, nre, rd); end
        exp_if_rdata = 32'hA5A5_1234;
        bv = 1'b1; btag = 32'h8; bdata = 32'hA5A5_1234;
    endtask
`endif

    task automatic test_random();
        int lat, nre, nwe, w, elat, estr;
        logic [31:0] sa, sw, rd, addr, wdata, edata;
        bit oth, aft, be, is_d, we, hit, ok;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_if_rdata = '0; exp_d_rdata = '0; exp_bus_err = 1'b0; bv = 1'b0;
        for (int i = 0; i < 60; i++) begin
            is_d  = 1'($urandom_range(0, 1));
            we    = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
            addr  = 32'($urandom_range(0, 3)) << 2;
            wdata = $urandom;
            w     = ($urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(0, 5));
            hit   = BUF && !is_d && bv && (btag == addr);
            if (hit) begin
                elat = 1; estr = 0; edata = bdata;
            end else if (w < TMO) begin
                elat = 2 + w; estr = w + 1;
                edata = (is_d && we) ? exp_d_rdata : ref_rd(addr);
            end else begin
                elat = TMO + 1; estr = TMO; edata = 32'hDEAD_BEEF;
                exp_bus_err = 1'b1;
            end
            if (is_d && we && addr == btag) bv = 1'b0;
            if (!is_d && !hit) begin
                if (w < TMO) begin bv = 1'b1; btag = addr; bdata = edata; end
                else bv = 1'b0;
            end
            if (is_d && we && w < TMO) ref_mem[addr] = wdata;
            if (is_d) exp_d_rdata = edata;
            else exp_if_rdata = edata;

            drive_txn(is_d, we, addr, wdata, w, lat, nre, nwe, sa, sw, rd, oth, aft, be);
            tests_run++;
            if (lat !== elat || nre + nwe !== estr || nwe !== (we ? estr : 0)) begin
                tests_failed++;
                $display("FAIL rnd_timing[%0d]: got lat=%0d re=%0d we=%0d expected lat=%0d strobes=%0d write=%0d", i, lat, nre, nwe, elat, estr, we);
            end
            ok = (estr == 0) || (sa === addr && (!we || sw === wdata));
            tests_run++;
            if (!ok) begin
                tests_failed++;
                $display("FAIL rnd_bus[%0d]: got addr=%h wdata=%h expected addr=%h wdata=%h", i, sa, sw, addr, wdata);
            end
            tests_run++;
            if (rd !== edata || be !== exp_bus_err || oth !== 1'b0 || aft !== 1'b0) begin
                tests_failed++;
                $display("FAIL rnd_result[%0d]: got data=%h err=%0d other=%0d after=%0d expected data=%h err=%0d 0 0", i, rd, be, oth, aft, edata, exp_bus_err);
            end
        end
    endtask

    initial begin
        mem_arr[32'h0]   = 32'h2402_0005;
        ref_mem[32'h0]   = 32'h2402_0005;
        mem_arr[32'h100] = 32'hCAFE_F00D;
        ref_mem[32'h100] = 32'hCAFE_F00D;
        test_reset();
        test_zero_wait_fetch();
        test_wait_load();
        test_simultaneous();
        test_timeout();
        test_reset_mid_access();
        test_zero_wait_fetch();
`ifdef CPU_MEM_ARB_FETCH_BUF_EN
        test_fetch_buffer();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Sits directly downstream of the multi-cycle MIPS core. Merges its instruction-fetch port (PC/Instruction) and its data port (Address/Write_data/MemRead/MemWrite/Read_data) onto one single-port, variable-latency memory.
- Uses a req/ready handshake toward the core and a strobe/ack handshake toward memory.
- Adds arbitration, a bus timeout and a sticky error flag, so the core can run against memories slower than one cycle.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width on all ports.
- TIMEOUT_CYCLES, 255, busy cycles without mem_ack before the access is aborted; counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held high until if_ready.
- if_addr  in  ADDR_W  fetch address (core PC).
- if_rdata  out  DATA_W  fetched instruction; registered, valid while if_ready=1, held afterwards.
- if_ready  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; held high until d_ready.
- d_we  in  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  in  ADDR_W  data address (core ALUOut).
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; registered, same timing as if_rdata.
- d_ready  out  1  one-cycle data completion pulse.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ack=1.
- mem_ack  in  1  memory completion; may be high in the first strobe cycle (zero wait).
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, asynchronous) clears every output and register:
  - state=IDLE; if_ready, d_ready, mem_re, mem_we, bus_err all 0.
  - if_rdata, d_rdata, mem_addr, mem_wdata all 0; timeout counter 0.
- All outputs are registered; there is no combinational path from any input to any output.
- FSM states:
  - IDLE: samples d_req and if_req.
    - d_req=1 -> latch d_addr/d_wdata/d_we into mem_*; mem_re=~d_we, mem_we=d_we; owner=D; go to BUSY.
    - else if_req=1 -> mem_addr=if_addr, mem_re=1; owner=I; go to BUSY.
    - Data has fixed priority over fetch when both are requested.
  - BUSY: strobes held stable; counter increments each cycle.
    - mem_ack=1 -> capture mem_rdata into the owner's rdata register (reads only; a write leaves d_rdata unchanged); drop strobes; pulse the owner's ready; go to DONE.
    - counter reaches TIMEOUT_CYCLES-1 without ack -> drop strobes; rdata := 32'hDEADBEEF; bus_err := 1; pulse ready; go to DONE.
    - A mem_ack arriving after the abort is ignored.
  - DONE: the owner's ready is high for exactly this cycle; requests are ignored; counter cleared; go to IDLE.
- Latency with a zero-wait memory: request sampled at edge k -> strobe during cycle k+1 -> ready during cycle k+2. With W wait cycles, ready comes W cycles later. Minimum spacing between accesses is 3 cycles.
- The requester must drop req in the cycle after it sees ready. A req still high in IDLE starts a new access.
- At most one of if_ready/d_ready is high in any cycle, and only the owner's ready fires.
- bus_err stays set until reset.
- Reset mid-access: strobes drop immediately (asynchronously); no ready is issued.

Optional Feature:
- Macro: CPU_MEM_ARB_FETCH_BUF_EN.
- When defined, a one-entry fetch buffer holds tag, data and a valid bit:
  - In IDLE, an if_req (with no d_req) whose if_addr equals a valid tag skips memory: if_rdata=buffer data, go directly to DONE (ready at k+1).
  - Every successful fetch fills the buffer.
  - Any data write whose d_addr matches the tag clears valid, as does a fetch timeout.
  - Reset clears valid.
- When undefined, every fetch goes to memory and no buffer logic exists.

Test Plan:
- Zero-wait fetch: if_addr=0x0000_0000, memory acks immediately with 0x2402_0005 -> if_ready high exactly 2 cycles after if_req is sampled, if_rdata=0x2402_0005, mem_re high exactly 1 cycle.
- 3-wait load: d_req, d_we=0, d_addr=0x100, ack after 3 cycles with 0xCAFE_F00D -> mem_re high 4 cycles, d_ready 1 cycle later, d_rdata=0xCAFE_F00D; if_ready stays 0.
- Simultaneous if_req and d_req (d_we=1, d_addr=0x40, d_wdata=0x1234_5678) -> write served first (mem_we=1, mem_wdata=0x1234_5678); fetch starts in the IDLE after DONE.
- Timeout with TIMEOUT_CYCLES=8 and no ack -> strobe high 8 cycles, ready pulse with rdata=0xDEAD_BEEF, bus_err=1 and still 1 after 20 idle cycles.
- rst driven low during BUSY, asynchronous to clk -> mem_re/mem_we/ready/bus_err go to 0 before the next edge; the first access after reset release behaves as in the zero-wait fetch case.
- With CPU_MEM_ARB_FETCH_BUF_EN: repeat fetch of 0x8 -> second if_ready at k+1 with no mem_re; a store to 0x8 followed by a fetch of 0x8 -> mem_re asserted again.
